seg_display_ctrl: RTL and testbench
===================================

// Module: seg_display_ctrl
// PURPOSE
//  Memory-mapped, time-multiplexed 7-segment display controller on the CPU I/O bus.
//  Scans NUM_DIGITS common-cathode digits of hex data.
//  Adds per-digit decimal points, blank and blink masks, leading-zero blanking,
//  byte-enable writes, register read-back and selectable output polarity.
// PARAMETERS
//  NUM_DIGITS  8      digits driven, 1..8; digit i shows DATA[4i+3:4i]
//  SCAN_DIV    50000  clk cycles each digit stays enabled
//  BLINK_DIV   25000000  clk cycles per blink half-period
//  ACTIVE_LOW  0      1: invert dig_en and seg_data at the output registers
// PORTS
//  clk       in   1           system clock, all logic on rising edge
//  rst       in   1           asynchronous, active-low reset
//  we        in   1           register write strobe, one cycle per write
//  addr      in   2           register select: 0 DATA, 1 DPBLK, 2 CTRL, 3 STAT
//  be        in   4           byte enables for the write; be[k] covers wdata[8k+7:8k]
//  wdata     in   32          write data
//  rdata     out  32          combinational read-back of the register at addr
//  dig_en    out  NUM_DIGITS  one-hot digit enable, registered
//  seg_data  out  8           {dp,g,f,e,d,c,b,a}, registered
// BEHAVIOUR
//  Registers (all reset to 0):
//   DATA:  [31:0] hex nibbles.
//   DPBLK: [7:0] dp mask, [15:8] blank mask.
//   CTRL:  [0] lzb_en, [1] blink_en, [15:8] blink mask.
//   STAT:  read-only {29'b0, idx}; writes to STAT are ignored.
//   Unused register bits read 0.
//  Writes: when we=1, each byte with be[k]=1 is updated at that edge; other bytes hold.
//  Scan counter:
//   - cnt counts 0..SCAN_DIV-1; idx advances when cnt==SCAN_DIV-1.
//   - idx wraps from NUM_DIGITS-1 to 0 (also when NUM_DIGITS is not a power of 2).
//  Blink timer: bcnt counts 0..BLINK_DIV-1; phase toggles at the terminal count.
//  Blanking: digit i is blank when any of the following holds:
//   - blank[i]=1;
//   - blink_en=1, blink[i]=1 and phase=1;
//   - lzb_en=1, i>0, and nibbles i..NUM_DIGITS-1 are all 0 (digit 0 is never LZ-blanked).
//  A blank digit drives seg_data=8'h00, DP included. dig_en stays asserted.
//  Decode table for nibble 0..F:
//   3F 06 5B 4F 66 6D 7D 07 7F 6F 77 7C 39 5E 79 71.
//   seg_data[7] = dp[i] when not blank.
//  Output timing:
//   - dig_en and seg_data are registered from the current idx and current registers.
//   - Both lag idx by exactly one cycle and always change on the same edge (no ghosting).
//   - A write at edge N is visible on seg_data at edge N+1.
//  Write and scan tick in the same cycle: both take effect; no priority conflict.
//  ACTIVE_LOW=1 inverts the final dig_en and seg_data values; reset values are inverted too.
//  Reset (rst=0, any time):
//   - cnt, idx, bcnt, phase and all registers go to 0 immediately.
//   - dig_en = one-hot bit 0; seg_data = 8'h3F (polarity applied).
//   - Scanning restarts from digit 0 on the first edge after release.
//  Mask and DATA bits for digits >= NUM_DIGITS are stored and read back, but have no display effect.
// TESTING  (bench uses SCAN_DIV=4, BLINK_DIV=16, NUM_DIGITS=8 unless noted)
//  1) Reset, write DATA=32'h1234ABCD with be=4'hF. Required response:
//     dig_en steps 01,02,04..80,01 every 4 cycles;
//     seg_data sequence 5E,39,7C,77,66,4F,5B,06.
//  2) Write DATA=32'hFFFFFFFF, then write be=4'b0010 with wdata=32'h00003C00.
//     Required: rdata@0 = 32'hFFFF3CFF; digit 2 shows 39, digit 3 shows 4F.
//  3) CTRL=1, DATA=32'h00000050. Required: digits 7..2 show 00, digit 1 shows 6D, digit 0 shows 3F.
//     Then DATA=0: only digit 0 shows 3F.
//  4) DPBLK=32'h00000401, DATA=0, CTRL=0. Required: digit 0 shows BF, digit 2 shows 00.
//  5) CTRL=32'h00000102. Required: digit 0 alternates 3F/00 every 16 cycles; other digits are steady.
//  6) Assert rst mid-scan at idx=5. Required: dig_en=01, seg_data=3F, STAT=0 at once.
//     Rerun with NUM_DIGITS=5 and ACTIVE_LOW=1: idx wraps 4->0; reset dig_en=5'b11110, seg_data=C0.

Source files
------------

// File: rtl/seg_display_ctrl.sv
// Memory-mapped, time-multiplexed 7-segment controller: scans NUM_DIGITS hex digits with
// decimal points, blank/blink masks, leading-zero blanking and selectable output polarity.
module seg_display_ctrl #(
    parameter int NUM_DIGITS = 8,
    parameter int SCAN_DIV   = 50000,
    parameter int BLINK_DIV  = 25000000,
    parameter bit ACTIVE_LOW = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we,
    input  logic [1:0]            addr,
    input  logic [3:0]            be,
    input  logic [31:0]           wdata,
    output logic [31:0]           rdata,
    output logic [NUM_DIGITS-1:0] dig_en,
    output logic [7:0]            seg_data
);

    localparam int CNT_W  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int BCNT_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [CNT_W-1:0]      CNT_LAST  = CNT_W'(SCAN_DIV - 1);
    localparam logic [BCNT_W-1:0]     BCNT_LAST = BCNT_W'(BLINK_DIV - 1);
    localparam logic [2:0]            IDX_LAST  = 3'(NUM_DIGITS - 1);
    localparam logic [7:0]            SEG_POL   = {8{ACTIVE_LOW}};
    localparam logic [NUM_DIGITS-1:0] DIG_POL   = {NUM_DIGITS{ACTIVE_LOW}};
    localparam logic [NUM_DIGITS-1:0] DIG_RST   = NUM_DIGITS'(1) ^ DIG_POL;

    logic [31:0]           data_r;
    logic [7:0]            dp_r;
    logic [7:0]            blank_r;
    logic                  lzb_en_r;
    logic                  blink_en_r;
    logic [7:0]            blink_r;
    logic [CNT_W-1:0]      cnt_r;
    logic [2:0]            idx_r;
    logic [BCNT_W-1:0]     bcnt_r;
    logic                  phase_r;
    logic [NUM_DIGITS-1:0] dig_en_r;
    logic [7:0]            seg_r;

    logic [3:0]            nibble_s;
    logic                  upper_nz_s;
    logic                  blank_s;
    logic [7:0]            seg_s;
    logic [NUM_DIGITS-1:0] dig_s;

    function automatic logic [6:0] seg_decode(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'h0:    seg = 7'h3F;
            4'h1:    seg = 7'h06;
            4'h2:    seg = 7'h5B;
            4'h3:    seg = 7'h4F;
            4'h4:    seg = 7'h66;
            4'h5:    seg = 7'h6D;
            4'h6:    seg = 7'h7D;
            4'h7:    seg = 7'h07;
            4'h8:    seg = 7'h7F;
            4'h9:    seg = 7'h6F;
            4'hA:    seg = 7'h77;
            4'hB:    seg = 7'h7C;
            4'hC:    seg = 7'h39;
            4'hD:    seg = 7'h5E;
            4'hE:    seg = 7'h79;
            4'hF:    seg = 7'h71;
            default: seg = 7'h00;
        endcase
        return seg;
    endfunction

    // Register file writes with per-byte enables; STAT is read-only.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            data_r     <= 32'h0;
            dp_r       <= 8'h0;
            blank_r    <= 8'h0;
            lzb_en_r   <= 1'b0;
            blink_en_r <= 1'b0;
            blink_r    <= 8'h0;
        end else if (we) begin
            case (addr)
                2'd0: begin
                    for (int k = 0; k < 4; k++) begin
                        if (be[k]) data_r[8*k +: 8] <= wdata[8*k +: 8];
                    end
                end
                2'd1: begin
                    if (be[0]) dp_r    <= wdata[7:0];
                    if (be[1]) blank_r <= wdata[15:8];
                end
                2'd2: begin
                    if (be[0]) {blink_en_r, lzb_en_r} <= wdata[1:0];
                    if (be[1]) blink_r <= wdata[15:8];
                end
                default: ;
            endcase
        end
    end

    // Digit scan: dwell SCAN_DIV cycles per digit, wrap after the last digit.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_r <= '0;
            idx_r <= 3'd0;
        end else if (cnt_r == CNT_LAST) begin
            cnt_r <= '0;
            idx_r <= (idx_r == IDX_LAST) ? 3'd0 : idx_r + 3'd1;
        end else begin
            cnt_r <= cnt_r + CNT_W'(1);
        end
    end

    // Blink half-period timer.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bcnt_r  <= '0;
            phase_r <= 1'b0;
        end else if (bcnt_r == BCNT_LAST) begin
            bcnt_r  <= '0;
            phase_r <= ~phase_r;
        end else begin
            bcnt_r  <= bcnt_r + BCNT_W'(1);
        end
    end

    // Current nibble and whether any displayed nibble at or above idx is nonzero.
    always_comb begin
        nibble_s   = 4'h0;
        upper_nz_s = 1'b0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            nibble_s   = (idx_r == 3'(k)) ? data_r[4*k +: 4] : nibble_s;
            upper_nz_s = upper_nz_s | ((3'(k) >= idx_r) && (data_r[4*k +: 4] != 4'h0));
        end
    end

    // Blanking and segment pattern for the digit currently selected.
    always_comb begin
        blank_s = blank_r[idx_r]
                | (blink_en_r & blink_r[idx_r] & phase_r)
                | (lzb_en_r & (idx_r != 3'd0) & ~upper_nz_s);
        if (blank_s) begin
            seg_s = 8'h00;
        end else begin
            seg_s = {dp_r[idx_r], seg_decode(nibble_s)};
        end
        for (int i = 0; i < NUM_DIGITS; i++) begin
            dig_s[i] = (idx_r == 3'(i));
        end
    end

    // Output registers: dig_en and seg_data always update on the same edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dig_en_r <= DIG_RST;
            seg_r    <= 8'h3F ^ SEG_POL;
        end else begin
            dig_en_r <= dig_s ^ DIG_POL;
            seg_r    <= seg_s ^ SEG_POL;
        end
    end

    // Combinational register read-back.
    always_comb begin
        case (addr)
            2'd0:    rdata = data_r;
            2'd1:    rdata = {16'h0, blank_r, dp_r};
            2'd2:    rdata = {16'h0, blink_r, 6'h0, blink_en_r, lzb_en_r};
            2'd3:    rdata = {29'h0, idx_r};
            default: rdata = 32'h0;
        endcase
    end

    assign dig_en   = dig_en_r;
    assign seg_data = seg_r;

endmodule

// File: tb/tb_seg_display_ctrl.sv
// Bench for seg_display_ctrl: directed scenarios plus random bus traffic, checked against
// an arithmetic model of scan position, blink phase and blanking rules.
module tb_seg_display_ctrl;

    localparam int SCAN  = 4;
    localparam int BLINK = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        we = 1'b0;
    logic [1:0]  addr = 2'd0;
    logic [3:0]  be = 4'h0;
    logic [31:0] wdata = 32'h0;
    logic [31:0] rdata8, rdata5;
    logic [7:0]  dig8;
    logic [4:0]  dig5;
    logic [7:0]  seg8, seg5;

    always #5 clk = ~clk;

    seg_display_ctrl #(.NUM_DIGITS(8), .SCAN_DIV(SCAN), .BLINK_DIV(BLINK), .ACTIVE_LOW(1'b0)) dut8 (
        .clk(clk), .rst(rst), .we(we), .addr(addr), .be(be), .wdata(wdata),
        .rdata(rdata8), .dig_en(dig8), .seg_data(seg8));

    seg_display_ctrl #(.NUM_DIGITS(5), .SCAN_DIV(SCAN), .BLINK_DIV(BLINK), .ACTIVE_LOW(1'b1)) dut5 (
        .clk(clk), .rst(rst), .we(we), .addr(addr), .be(be), .wdata(wdata),
        .rdata(rdata5), .dig_en(dig5), .seg_data(seg5));

    int n_vec = 0;
    int n_err = 0;

    // Reference state: register contents and number of clock edges since reset release.
    logic [31:0] m_data, m_dpblk, m_ctrl;
    int unsigned m_t;
    logic [7:0]  seg_tab [16] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
                                  8'h7F, 8'h6F, 8'h77, 8'h7C, 8'h39, 8'h5E, 8'h79, 8'h71};

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic int model_idx(input int n, input int unsigned t);
        return int'((t / SCAN) % n);
    endfunction

    function automatic logic [7:0] model_seg(input int n, input int d, input int unsigned t);
        logic [31:0] vis;
        logic [3:0]  nib;
        bit          phase, blank;
        vis   = (n == 8) ? m_data : (m_data & ((32'h1 << (4 * n)) - 32'h1));
        nib   = 4'((m_data >> (4 * d)) & 32'hF);
        phase = ((t / BLINK) % 2) == 1;
        blank = m_dpblk[8 + d] || (m_ctrl[1] && m_ctrl[8 + d] && phase)
             || (m_ctrl[0] && d > 0 && (vis >> (4 * d)) == 32'h0);
        if (blank) return 8'h00;
        return seg_tab[nib] | (m_dpblk[d] ? 8'h80 : 8'h00);
    endfunction

    function automatic logic [31:0] model_read(input int n, input logic [1:0] a);
        case (a)
            2'd0:    return m_data;
            2'd1:    return m_dpblk;
            2'd2:    return m_ctrl;
            default: return 32'(model_idx(n, m_t));
        endcase
    endfunction

    function automatic logic [31:0] wmerge(input logic [31:0] old, input logic [31:0] d,
                                           input logic [3:0] b, input logic [31:0] rmask);
        logic [31:0] m;
        m = {{8{b[3]}}, {8{b[2]}}, {8{b[1]}}, {8{b[0]}}} & rmask;
        return (old & ~m) | (d & m);
    endfunction

    // One bus cycle: predict the next output registers from pre-edge state, then compare.
    task automatic cycle(input logic w, input logic [1:0] a, input logic [3:0] b, input logic [31:0] d);
        logic [7:0] e8_seg, e5_seg, e8_dig;
        logic [4:0] e5_dig;
        int i8, i5;
        we = w; addr = a; be = b; wdata = d;
        i8 = model_idx(8, m_t);
        i5 = model_idx(5, m_t);
        e8_seg = model_seg(8, i8, m_t);
        e5_seg = ~model_seg(5, i5, m_t);
        e8_dig = 8'(1 << i8);
        e5_dig = ~5'(1 << i5);
        if (w) begin
            case (a)
                2'd0:    m_data  = wmerge(m_data, d, b, 32'hFFFF_FFFF);
                2'd1:    m_dpblk = wmerge(m_dpblk, d, b, 32'h0000_FFFF);
                2'd2:    m_ctrl  = wmerge(m_ctrl, d, b, 32'h0000_FF03);
                default: ;
            endcase
        end
        m_t++;
        @(posedge clk);
        @(negedge clk);
        we = 1'b0;
        check_val("dig8", 32'(dig8), 32'(e8_dig));
        check_val("seg8", 32'(seg8), 32'(e8_seg));
        check_val("dig5", 32'(dig5), 32'(e5_dig));
        check_val("seg5", 32'(seg5), 32'(e5_seg));
        check_val("rdata8", rdata8, model_read(8, a));
        check_val("rdata5", rdata5, model_read(5, a));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 2'd3, 4'h0, 32'h0);
    endtask

    // Asynchronous reset taken between clock edges; outputs must change before any edge.
    task automatic do_reset();
        @(negedge clk);
        we = 1'b0; addr = 2'd3; be = 4'h0; wdata = 32'h0;
        #2 rst = 1'b0;
        #1;
        check_val("rst_dig8", 32'(dig8), 32'h01);
        check_val("rst_seg8", 32'(seg8), 32'h3F);
        check_val("rst_dig5", 32'(dig5), 32'h1E);
        check_val("rst_seg5", 32'(seg5), 32'hC0);
        check_val("rst_stat8", rdata8, 32'h0);
        check_val("rst_stat5", rdata5, 32'h0);
        m_data = 32'h0; m_dpblk = 32'h0; m_ctrl = 32'h0; m_t = 0;
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        m_data = 32'h0; m_dpblk = 32'h0; m_ctrl = 32'h0; m_t = 0;
        do_reset();

        // Hex scan of a mixed pattern.
        cycle(1'b1, 2'd0, 4'hF, 32'h1234_ABCD);
        idle(40);

        // Byte-enable write.
        cycle(1'b1, 2'd0, 4'hF, 32'hFFFF_FFFF);
        cycle(1'b1, 2'd0, 4'b0010, 32'h0000_3C00);
        check_val("be_merge", rdata8, 32'hFFFF_3CFF);
        idle(34);

        // Leading-zero blanking, including all-zero data.
        cycle(1'b1, 2'd2, 4'hF, 32'h0000_0001);
        cycle(1'b1, 2'd0, 4'hF, 32'h0000_0050);
        idle(34);
        cycle(1'b1, 2'd0, 4'hF, 32'h0000_0000);
        idle(34);

        // Decimal point and blank mask.
        cycle(1'b1, 2'd1, 4'hF, 32'h0000_0401);
        cycle(1'b1, 2'd0, 4'hF, 32'h0000_0000);
        cycle(1'b1, 2'd2, 4'hF, 32'h0000_0000);
        idle(34);

        // Blink on digit 0; STAT write is ignored.
        cycle(1'b1, 2'd1, 4'hF, 32'h0000_0000);
        cycle(1'b1, 2'd2, 4'hF, 32'h0000_0102);
        cycle(1'b1, 2'd3, 4'hF, 32'hFFFF_FFFF);
        idle(80);

        // Reset mid-scan at digit 5.
        for (int i = 0; i < 40 && model_idx(8, m_t) != 5; i++) cycle(1'b0, 2'd3, 4'h0, 32'h0);
        check_val("stat_at5", rdata8, 32'h5);
        do_reset();
        idle(12);

        // Random bus traffic with occasional resets.
        for (int i = 0; i < 2500; i++) begin
            if ($urandom_range(0, 399) == 0) begin
                do_reset();
            end else if ($urandom_range(0, 3) == 0) begin
                cycle(1'b1, 2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)),
                      $urandom >> $urandom_range(0, 31));
            end else begin
                cycle(1'b0, 2'($urandom_range(0, 3)), 4'h0, 32'h0);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
